// File: rtl/spi_mem_master.sv
// SPI transaction sequencer for the spiMemory slave: accepts one read/write request
// at a time and serialises it MSB first as address, R/W bit, then data.
module spi_mem_master #(
   parameter int CLK_DIV    = 4,
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 8,
   parameter int READ_GAP   = 2,
   parameter int WRITE_HOLD = 1,
   parameter int CS_IDLE    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              busy,
   output logic              sclk,
   output logic              cs,
   output logic              mosi,
   input  logic              miso
);
   localparam int TX_W  = ADDR_W + 1 + DATA_W;
   localparam int RX_W  = DATA_W - 1;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ADDR, S_GAP, S_DATA, S_HOLD, S_CSHIGH, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DIV_W-1:0]  r_div;
   logic              r_half;
   logic [CNT_W-1:0]  r_bit;
   logic              r_sclk;
   logic              r_cs;
   logic              r_rw;
   logic [TX_W-1:0]   r_tx;
   logic [RX_W-1:0]   r_rx;
   logic [DATA_W-1:0] r_rdata;

   logic w_accept;
   logic w_active;
   logic w_timed;
   logic w_half_end;
   logic w_fall;
   logic w_per_end;
   logic w_last;

   function automatic logic is_active(input state_t s);
      return (s == S_ADDR) || (s == S_GAP) || (s == S_DATA) || (s == S_HOLD);
   endfunction

   // Index of the final sclk period spent in each timed state.
   function automatic logic [CNT_W-1:0] last_idx(input state_t s);
      case (s)
         S_ADDR:   return CNT_W'(ADDR_W);
         S_GAP:    return CNT_W'(READ_GAP - 1);
         S_DATA:   return CNT_W'(DATA_W - 1);
         S_HOLD:   return CNT_W'(WRITE_HOLD - 1);
         S_CSHIGH: return CNT_W'(CS_IDLE - 1);
         default:  return '0;
      endcase
   endfunction

   assign w_accept   = (r_state == S_IDLE) && req_valid;
   assign w_active   = is_active(r_state);
   assign w_timed    = w_active || (r_state == S_SETUP) || (r_state == S_CSHIGH);
   assign w_half_end = (r_div == DIV_W'(CLK_DIV - 1));
   assign w_fall     = w_active && w_half_end && !r_half;
   assign w_per_end  = w_timed && w_half_end && r_half;
   assign w_last     = (r_bit == last_idx(r_state));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      busy        = 1'b1;
      resp_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) w_state_nxt = S_SETUP;
         end
         S_SETUP:  if (w_per_end) w_state_nxt = S_ADDR;
         S_ADDR: begin
            if (w_per_end && w_last)
               w_state_nxt = (r_rw && READ_GAP > 0) ? S_GAP : S_DATA;
         end
         S_GAP:    if (w_per_end && w_last) w_state_nxt = S_DATA;
         S_DATA: begin
            if (w_per_end && w_last)
               w_state_nxt = (!r_rw && WRITE_HOLD > 0) ? S_HOLD : S_CSHIGH;
         end
         S_HOLD:   if (w_per_end && w_last) w_state_nxt = S_CSHIGH;
         S_CSHIGH: if (w_per_end && w_last) w_state_nxt = S_DONE;
         S_DONE: begin
            resp_valid  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Every timed state runs in half-periods of CLK_DIV clocks; SETUP starts in the
   // second half so it lasts a single half. sclk is high in the first half only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div   <= '0;
         r_half  <= 1'b0;
         r_bit   <= '0;
         r_sclk  <= 1'b0;
         r_cs    <= 1'b1;
         r_rw    <= 1'b0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_rdata <= '0;
      end else if (w_accept) begin
         r_rw   <= req_rw;
         r_tx   <= {req_addr, req_rw, req_wdata & {DATA_W{!req_rw}}};
         r_cs   <= 1'b0;
         r_div  <= '0;
         r_half <= 1'b1;
         r_bit  <= '0;
      end else if (w_timed) begin
         r_div <= w_half_end ? '0 : r_div + 1'b1;
         if (w_half_end) r_half <= !r_half;
         // Zeros shift in behind the frame, so mosi rests low through GAP/HOLD.
         if (w_fall) begin
            r_sclk <= 1'b0;
            r_tx   <= r_tx << 1;
            if (r_state == S_DATA && r_rw) begin
               r_rx <= RX_W'({r_rx, miso});
               if (w_last) r_rdata <= {r_rx, miso};
            end
         end
         if (w_per_end) begin
            r_bit  <= w_last ? '0 : r_bit + 1'b1;
            r_sclk <= is_active(w_state_nxt);
            if (w_state_nxt == S_CSHIGH) r_cs <= 1'b1;
         end
      end
   end

   assign sclk       = r_sclk;
   assign cs         = r_cs;
   assign mosi       = r_tx[TX_W-1];
   assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: a behavioural SPI memory slave plus a frame-level
// reference model (bit pattern, edge count, cs timing, read data).
module tb_spi_mem_master;
   localparam int CLK_DIV    = 4;
   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;
   localparam int READ_GAP   = 2;
   localparam int WRITE_HOLD = 1;
   localparam int CS_IDLE    = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_rw = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              busy;
   logic              sclk;
   logic              cs;
   logic              mosi;
   logic              miso = 1'b0;

   always #5 clk = ~clk;

   spi_mem_master #(
      .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .READ_GAP(READ_GAP), .WRITE_HOLD(WRITE_HOLD), .CS_IDLE(CS_IDLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
      .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W-1:0] slv_mem [1 << ADDR_W];
   logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
   logic [DATA_W-1:0] exp_rdata = '0;

   int          cyc = 0;
   int          resp_cnt = 0;
   int          sclk_cs_viol = 0;
   int          cur_edges = 0;
   int          fall_cyc = 0;
   logic [31:0] cur_bits = '0;
   logic        slv_is_rd = 1'b0;
   logic [DATA_W-1:0] slv_rd = '0;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   int          q_fall[$];
   int          q_rise[$];
   int          q_edges[$];
   logic [31:0] q_bits[$];

   // Slave + monitor: samples mosi at sclk rise, drives miso after sclk fall,
   // commits complete write frames when cs rises.
   always @(negedge clk) begin
      cyc++;
      if (resp_valid) resp_cnt++;
      if (cs && sclk) sclk_cs_viol++;
      if (prev_cs && !cs) begin
         fall_cyc  = cyc;
         cur_edges = 0;
         cur_bits  = '0;
         slv_is_rd = 1'b0;
      end
      if (!cs && !prev_sclk && sclk) begin
         cur_bits = {cur_bits[30:0], mosi};
         cur_edges++;
         if (cur_edges == ADDR_W + 1) begin
            slv_is_rd = mosi;
            slv_rd    = slv_mem[cur_bits[ADDR_W:1]];
         end
      end
      if (!cs && prev_sclk && !sclk) begin
         if (slv_is_rd && cur_edges >= ADDR_W + 1 + READ_GAP && cur_edges < ADDR_W + 1 + READ_GAP + DATA_W)
            miso = slv_rd[DATA_W - 1 - (cur_edges - (ADDR_W + 1 + READ_GAP))];
         else
            miso = 1'b0;
      end
      if (!prev_cs && cs) begin
         q_fall.push_back(fall_cyc);
         q_rise.push_back(cyc);
         q_edges.push_back(cur_edges);
         q_bits.push_back(cur_bits);
         if (!slv_is_rd && cur_edges == ADDR_W + 1 + DATA_W + WRITE_HOLD && !cur_bits[DATA_W + WRITE_HOLD])
            slv_mem[cur_bits[ADDR_W + DATA_W + WRITE_HOLD : DATA_W + WRITE_HOLD + 1]] =
               cur_bits[DATA_W + WRITE_HOLD - 1 : WRITE_HOLD];
         miso = 1'b0;
      end
      prev_cs   = cs;
      prev_sclk = sclk;
   end

   function automatic int exp_edges(input bit rw);
      return ADDR_W + 1 + DATA_W + (rw ? READ_GAP : WRITE_HOLD);
   endfunction

   function automatic int exp_low(input bit rw);
      return CLK_DIV + exp_edges(rw) * 2 * CLK_DIV;
   endfunction

   function automatic logic [31:0] exp_bits(input bit rw, input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] d);
      logic [31:0] v;
      v = 32'(a);
      v = (v << 1) | 32'(rw);
      v = (v << DATA_W) | (rw ? 32'd0 : 32'(d));
      v = v << (rw ? READ_GAP : WRITE_HOLD);
      return v;
   endfunction

   task automatic do_txn(input bit rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit scramble, output bit tmo);
      int n;
      bit fin;
      tmo = 1'b0;
      fin = 1'b0;
      n   = 0;
      @(negedge clk);
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!fin) begin
         @(negedge clk);
         if (resp_valid) fin = 1'b1;
         else if (n >= 2000) begin
            tmo = 1'b1;
            fin = 1'b1;
         end else begin
            n++;
            if (scramble) begin
               req_valid = 1'($urandom_range(0, 1));
               req_rw    = 1'($urandom_range(0, 1));
               req_addr  = ADDR_W'($urandom);
               req_wdata = DATA_W'($urandom);
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      int r0;
      int bad;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({cs, sclk, mosi, resp_valid, busy, req_ready, resp_rdata} !== {6'b100001, 8'h00}) begin
         n_err++;
         $display("FAIL reset_state: got cs/sclk/mosi/rv/busy/rdy/rdata=%b got rdata %h, want 100001 rdata 00",
                  {cs, sclk, mosi, resp_valid, busy, req_ready}, resp_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = 7'h2A;
      req_wdata = 8'h5B;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (cur_edges < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (n >= 200 || {cs, sclk, mosi, resp_valid} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_abort: got cs/sclk/mosi/rv=%b (wait=%0d), want 1000", {cs, sclk, mosi, resp_valid}, n);
      end
      n_vec++;
      if ({busy, req_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL reset_abort_ctrl: got busy/rdy=%b want 01", {busy, req_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      r0  = resp_cnt;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (!req_ready || busy || resp_valid || !cs) bad++;
      end
      n_vec++;
      if (bad != 0 || resp_cnt != r0) begin
         n_err++;
         $display("FAIL reset_quiet: got %0d bad cycles, %0d resp pulses; want 0, 0", bad, resp_cnt - r0);
      end
      exp_rdata = '0;
   endtask

   task automatic test_write();
      bit tmo;
      int r0;
      r0 = resp_cnt;
      do_txn(1'b0, 7'h55, 8'hA6, 1'b0, tmo);
      @(negedge clk);
      ref_mem[7'h55] = 8'hA6;
      n_vec++;
      if (tmo || resp_cnt != r0 + 1) begin
         n_err++;
         $display("FAIL write_resp: got %0d pulses tmo=%0d, want 1", resp_cnt - r0, tmo);
      end
      n_vec++;
      if (q_edges[$] != 17 || q_bits[$] !== 32'b1010101_0_10100110_0) begin
         n_err++;
         $display("FAIL write_frame: got %0d edges bits %b, want 17 edges 10101010101001100", q_edges[$], q_bits[$]);
      end
      n_vec++;
      if (q_rise[$] - q_fall[$] != 140) begin
         n_err++;
         $display("FAIL write_cs_low: got %0d want 140", q_rise[$] - q_fall[$]);
      end
      n_vec++;
      if (resp_rdata !== exp_rdata || busy !== 1'b0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL write_rdata: got rdata %h busy %b rdy %b, want %h 0 1", resp_rdata, busy, req_ready, exp_rdata);
      end
   endtask

   task automatic test_read();
      bit tmo;
      int r0;
      slv_mem[7'h13] = 8'hC3;
      ref_mem[7'h13] = 8'hC3;
      r0 = resp_cnt;
      do_txn(1'b1, 7'h13, 8'h00, 1'b0, tmo);
      @(negedge clk);
      exp_rdata = 8'hC3;
      n_vec++;
      if (tmo || resp_cnt != r0 + 1) begin
         n_err++;
         $display("FAIL read_resp: got %0d pulses tmo=%0d, want 1", resp_cnt - r0, tmo);
      end
      n_vec++;
      if (q_edges[$] != 18 || q_bits[$] !== exp_bits(1'b1, 7'h13, 8'h00)) begin
         n_err++;
         $display("FAIL read_frame: got %0d edges bits %b, want 18 edges %b", q_edges[$], q_bits[$], exp_bits(1'b1, 7'h13, 8'h00));
      end
      n_vec++;
      if (q_rise[$] - q_fall[$] != 148) begin
         n_err++;
         $display("FAIL read_cs_low: got %0d want 148", q_rise[$] - q_fall[$]);
      end
      n_vec++;
      if (resp_rdata !== 8'hC3) begin
         n_err++;
         $display("FAIL read_rdata: got %h want c3", resp_rdata);
      end
   endtask

   task automatic test_ignore_busy();
      bit tmo;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = ADDR_W'($urandom);
      d = DATA_W'($urandom);
      do_txn(1'b0, a, d, 1'b1, tmo);
      @(negedge clk);
      ref_mem[a] = d;
      n_vec++;
      if (tmo || q_bits[$] !== exp_bits(1'b0, a, d)) begin
         n_err++;
         $display("FAIL busy_write_frame: got %b want %b tmo=%0d", q_bits[$], exp_bits(1'b0, a, d), tmo);
      end
      do_txn(1'b1, a, 8'h00, 1'b1, tmo);
      @(negedge clk);
      exp_rdata = ref_mem[a];
      n_vec++;
      if (tmo || q_bits[$] !== exp_bits(1'b1, a, 8'h00) || resp_rdata !== exp_rdata) begin
         n_err++;
         $display("FAIL busy_read: got bits %b rdata %h, want %b %h", q_bits[$], resp_rdata, exp_bits(1'b1, a, 8'h00), exp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      int qs;
      int seen;
      int n;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a    = ADDR_W'($urandom);
      d    = DATA_W'($urandom);
      qs   = q_rise.size();
      seen = 0;
      n    = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      req_rw = 1'b1;
      while (seen < 2 && n < 2000) begin
         @(negedge clk);
         n++;
         if (resp_valid) seen++;
      end
      req_valid = 1'b0;
      @(negedge clk);
      ref_mem[a] = d;
      exp_rdata  = d;
      n_vec++;
      if (seen != 2 || q_rise.size() != qs + 2) begin
         n_err++;
         $display("FAIL b2b_count: got %0d pulses %0d frames, want 2 2", seen, q_rise.size() - qs);
      end else begin
         n_vec++;
         if (q_fall[qs + 1] - q_rise[qs] != CS_IDLE * 2 * CLK_DIV + 2) begin
            n_err++;
            $display("FAIL b2b_gap: got %0d want %0d", q_fall[qs + 1] - q_rise[qs], CS_IDLE * 2 * CLK_DIV + 2);
         end
         n_vec++;
         if (q_bits[qs] !== exp_bits(1'b0, a, d) || q_bits[qs + 1] !== exp_bits(1'b1, a, 8'h00)) begin
            n_err++;
            $display("FAIL b2b_frames: got %b %b", q_bits[qs], q_bits[qs + 1]);
         end
      end
      n_vec++;
      if (resp_rdata !== exp_rdata) begin
         n_err++;
         $display("FAIL b2b_rdata: got %h want %h", resp_rdata, exp_rdata);
      end
   endtask

   task automatic test_memory();
      bit tmo;
      logic [ADDR_W-1:0] addrs [2];
      logic [DATA_W-1:0] datas [2];
      addrs[0] = 7'h7F;
      datas[0] = 8'h3C;
      addrs[1] = 7'h00;
      datas[1] = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         do_txn(1'b0, addrs[i], datas[i], 1'b0, tmo);
         ref_mem[addrs[i]] = datas[i];
         do_txn(1'b1, addrs[i], 8'h00, 1'b0, tmo);
         @(negedge clk);
         exp_rdata = ref_mem[addrs[i]];
         n_vec++;
         if (tmo || resp_rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL mem_roundtrip[%0d]: got %h want %h tmo=%0d", i, resp_rdata, exp_rdata, tmo);
         end
      end
   endtask

   task automatic test_random();
      bit tmo;
      bit rw;
      int r0;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      for (int i = 0; i < 16; i++) begin
         rw = 1'($urandom_range(0, 1));
         a  = ADDR_W'($urandom_range(0, 15));
         d  = DATA_W'($urandom);
         r0 = resp_cnt;
         do_txn(rw, a, d, 1'($urandom_range(0, 1)), tmo);
         @(negedge clk);
         if (rw) exp_rdata = ref_mem[a];
         else    ref_mem[a] = d;
         n_vec++;
         if (tmo || resp_cnt != r0 + 1 || q_edges[$] != exp_edges(rw)) begin
            n_err++;
            $display("FAIL rand[%0d]_resp: pulses %0d edges %0d, want 1 %0d", i, resp_cnt - r0, q_edges[$], exp_edges(rw));
         end
         n_vec++;
         if (q_bits[$] !== exp_bits(rw, a, d) || q_rise[$] - q_fall[$] != exp_low(rw)) begin
            n_err++;
            $display("FAIL rand[%0d]_frame: bits %b low %0d, want %b %0d", i, q_bits[$], q_rise[$] - q_fall[$], exp_bits(rw, a, d), exp_low(rw));
         end
         n_vec++;
         if (resp_rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL rand[%0d]_rdata: got %h want %h", i, resp_rdata, exp_rdata);
         end
      end
      n_vec++;
      if (sclk_cs_viol != 0) begin
         n_err++;
         $display("FAIL sclk_idle: got %0d cycles with sclk high while cs high, want 0", sclk_cs_viol);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         slv_mem[i] = DATA_W'($urandom);
         ref_mem[i] = slv_mem[i];
      end
      test_reset();
      test_write();
      test_read();
      test_ignore_busy();
      test_back_to_back();
      test_memory();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- Parallel-to-SPI transaction sequencer that drives the spiMemory slave's sclk/cs/mosi pins and samples miso.
- Accepts one read or write request at a time over a valid/ready handshake. Serialises address, R/W and data; returns read data with a one-cycle response pulse.
- Sits between on-chip logic (CPU or test harness) and the SPI memory, replacing hand-driven pin stimulus.

Parameters:
- CLK_DIV, 4, sclk half-period in clk cycles (≥2); sclk period = 2*CLK_DIV.
- ADDR_W, 7, address bits sent per frame.
- DATA_W, 8, data bits per frame.
- READ_GAP, 2, sclk periods between R/W bit and first miso data bit (memory read + shift-register load).
- WRITE_HOLD, 1, sclk periods cs stays low after last write data bit (memory commit).
- CS_IDLE, 1, minimum sclk periods cs stays high between frames.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer on req_valid&&req_ready at clk rising edge
- req_rw  in  1  1=read, 0=write
- req_addr  in  ADDR_W  memory address
- req_wdata  in  DATA_W  write data (ignored for reads)
- resp_valid  out  1  one-cycle pulse at end of every transaction
- resp_rdata  out  DATA_W  last read data; held until next read completes
- busy  out  1  high from acceptance until resp_valid cycle inclusive
- sclk  out  1  serial clock to spiMemory sclk_pin
- cs  out  1  active-low chip select to spiMemory cs_pin
- mosi  out  1  serial data to memory
- miso  in  1  serial data from memory

Behaviour:
- Reset (async, rst_n=0): state IDLE; sclk=0, cs=1, mosi=0, resp_valid=0, resp_rdata=0, busy=0, divider/bit counters=0; req_ready=1 once in IDLE. Reset mid-frame aborts immediately: cs high, sclk low, no resp_valid.
- Request fields are captured into internal registers on acceptance; later input changes are ignored. req_valid while busy is ignored (req_ready=0).
- Frame format, MSB first: addr[ADDR_W-1:0], R/W bit, then DATA_W data bits (mosi for write, miso for read).
- Edge rules:
  - Memory samples mosi on sclk rising edge; master changes mosi only in the clk cycle sclk falls, or at cs fall for the first bit.
  - Master samples miso in the clk cycle sclk goes high→low, i.e. end of high half.
  - sclk idles low and is low whenever cs is high.
- States:
  - IDLE: on accept → SETUP; cs=0 and mosi=first addr bit in the next cycle.
  - SETUP: sclk low for CLK_DIV cycles → ADDR.
  - ADDR: ADDR_W+1 sclk periods (high half then low half); last bit is R/W. → GAP if read, DATA if write.
  - GAP: READ_GAP sclk periods; sclk keeps toggling; mosi=0; miso ignored. → DATA.
  - DATA: DATA_W periods. Write shifts wdata out. Read shifts miso into a shift register; resp_rdata updated when the last bit is sampled. Write → HOLD; read → CSHIGH.
  - HOLD: WRITE_HOLD periods, sclk toggling, mosi=0. → CSHIGH.
  - CSHIGH: cs=1, sclk=0 for CS_IDLE*2*CLK_DIV cycles. → DONE.
  - DONE: resp_valid=1 for one cycle. → IDLE.
- cs low duration with defaults:
  - Write: CLK_DIV + (ADDR_W+1+DATA_W+WRITE_HOLD)*2*CLK_DIV = 140 clk.
  - Read: CLK_DIV + (ADDR_W+1+READ_GAP+DATA_W)*2*CLK_DIV = 148 clk.
- Exactly ADDR_W+1+DATA_W+WRITE_HOLD (write) or ADDR_W+1+READ_GAP+DATA_W (read) sclk rising edges per frame.
- Back-to-back: request held valid is accepted in the cycle after DONE. cs stays high ≥ CS_IDLE*2*CLK_DIV+2 clk between frames.

Test Plan:
- Reset: assert rst_n=0 mid-ADDR → cs=1, sclk=0, mosi=0, resp_valid=0 in the same cycle; after release req_ready=1, busy=0, no spurious resp_valid for 200 cycles.
- Write addr=0x55, wdata=0xA6 → mosi sampled on sclk rising edges = 1010101_0_10100110; 17 rising edges; cs low 140 clk; one resp_valid; resp_rdata unchanged.
- Read addr=0x13 with behavioural slave driving 0xC3 MSB first after READ_GAP → 18 rising edges; cs low 148 clk; resp_rdata=0xC3 on resp_valid.
- req_valid toggled with changing addr/wdata during busy → ignored; transmitted frame matches the values captured at acceptance.
- Back-to-back write then read, req_valid held high → second cs fall exactly CS_IDLE*2*CLK_DIV+2 clk after first cs rise; two resp_valid pulses.
- Integration with spiMemory: write 0x3C to addr 0x7F, then read addr 0x7F → resp_rdata=0x3C; repeat for addr 0x00 with data 0xFF.
